// File: rtl/dmem_ctrl.sv
// Data-memory controller: store write buffer plus a load/store FSM
// sharing one single-outstanding request port toward memory.
module dmem_ctrl #(
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_wr_req,
    input  logic [31:0] core_wr_addr,
    input  logic [3:0]  core_wr_byte,
    input  logic [31:0] core_wr_data,
    output logic        core_wr_ready,
    input  logic        core_rd_req,
    input  logic [31:0] core_rd_addr,
    output logic        core_rd_ready,
    output logic [31:0] dmem_read_data,
    output logic        dmem_read_valid,
    output logic        dmem_write_valid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_HAZ,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t state;

    logic [29:0] wb_addr [WBUF_DEPTH];
    logic [3:0]  wb_strb [WBUF_DEPTH];
    logic [31:0] wb_data [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] vld;

    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   rd_addr;

    logic full, empty, push, pop, drain, hazard;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(WBUF_DEPTH));
    assign empty = (count == '0);
    assign push  = core_wr_req && !full;
    assign drain = (state == WR_REQ) || (state == RD_HAZ && !empty);
    assign pop   = drain && mem_req_ready;

    assign core_wr_ready = !full;
    assign core_rd_ready = (state == IDLE);

    assign mem_req_valid = drain || (state == RD_REQ);
    assign mem_we        = drain;
    assign mem_addr      = drain ? {wb_addr[rptr], 2'b00}
                                 : {rd_addr[31:2], 2'b00};
    assign mem_wstrb     = drain ? wb_strb[rptr] : 4'b0000;
    assign mem_wdata     = drain ? wb_data[rptr] : 32'h0;

    // Only entries present before this cycle's push take part in the check
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (vld[i] && wb_addr[i] == core_rd_addr[31:2]) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wptr] <= core_wr_addr[31:2];
            wb_strb[wptr] <= core_wr_byte;
            wb_data[wptr] <= core_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            count <= count_next;
            if (pop) begin
                rptr      <= nxt(rptr);
                vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr      <= nxt(wptr);
                vld[wptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            rd_addr          <= 32'h0;
            dmem_read_data   <= 32'h0;
            dmem_read_valid  <= 1'b0;
            dmem_write_valid <= 1'b0;
        end else begin
            dmem_write_valid <= pop;
            dmem_read_valid  <= (state == RD_WAIT) && mem_rsp_valid;
            unique case (state)
                IDLE: begin
                    if (core_rd_req) begin
                        rd_addr <= core_rd_addr;
                        state   <= hazard ? RD_HAZ : RD_REQ;
                    end else if (!empty) begin
                        state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) state <= IDLE;
                end
                RD_HAZ: begin
                    if (count_next == '0) state <= RD_REQ;
                end
                RD_REQ: begin
                    if (mem_req_ready) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        dmem_read_data <= mem_rsp_data;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused;
    assign unused = ^{core_wr_addr[1:0], rd_addr[1:0]};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: store buffer, load ordering, hazards,
// reset during a read and request stability under back-pressure.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_wr_req;
    logic [31:0] core_wr_addr;
    logic [3:0]  core_wr_byte;
    logic [31:0] core_wr_data;
    logic        core_wr_ready;
    logic        core_rd_req;
    logic [31:0] core_rd_addr;
    logic        core_rd_ready;
    logic [31:0] dmem_read_data;
    logic        dmem_read_valid;
    logic        dmem_write_valid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.WBUF_DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .core_wr_req(core_wr_req),
        .core_wr_addr(core_wr_addr),
        .core_wr_byte(core_wr_byte),
        .core_wr_data(core_wr_data),
        .core_wr_ready(core_wr_ready),
        .core_rd_req(core_rd_req),
        .core_rd_addr(core_rd_addr),
        .core_rd_ready(core_rd_ready),
        .dmem_read_data(dmem_read_data),
        .dmem_read_valid(dmem_read_valid),
        .dmem_write_valid(dmem_write_valid),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
        core_wr_req  = 1'b1;
        core_wr_addr = a;
        core_wr_byte = b;
        core_wr_data = d;
        step();
        core_wr_req = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic we,
                            input logic [31:0] addr);
        int n = 0;
        while (!mem_req_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_addr"}, mem_addr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        core_wr_req   = 1'b0;
        core_wr_addr  = 32'h0;
        core_wr_byte  = 4'h0;
        core_wr_data  = 32'h0;
        core_rd_req   = 1'b0;
        core_rd_addr  = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        step();
        step();
        chk("rst_rd_ready", 32'(core_rd_ready), 32'd1);
        chk("rst_wr_ready", 32'(core_wr_ready), 32'd1);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_rdata", dmem_read_data, 32'h0);
        chk("rst_rvalid", 32'(dmem_read_valid), 32'd0);
        chk("rst_wvalid", 32'(dmem_write_valid), 32'd0);
        reset = 1'b1;
        step();

        // store then idle
        mem_req_ready = 1'b1;
        push(32'h104, 4'b0011, 32'h0000BEEF);
        chk("st_idle_valid", 32'(mem_req_valid), 32'd0);
        step();
        chk("st_valid", 32'(mem_req_valid), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h104);
        chk("st_strb", 32'(mem_wstrb), 32'h3);
        chk("st_data", mem_wdata, 32'h0000BEEF);
        step();
        chk("st_wvalid", 32'(dmem_write_valid), 32'd1);
        chk("st_done_valid", 32'(mem_req_valid), 32'd0);
        step();
        chk("st_wvalid_pulse", 32'(dmem_write_valid), 32'd0);
        chk("st_empty", 32'(mem_req_valid), 32'd0);

        // fill the buffer under back-pressure
        mem_req_ready = 1'b0;
        core_wr_req   = 1'b1;
        core_wr_byte  = 4'hF;
        core_wr_addr  = 32'h400;
        core_wr_data  = 32'h1;
        step();
        core_wr_addr = 32'h404;
        core_wr_data = 32'h2;
        step();
        chk("fill_full", 32'(core_wr_ready), 32'd0);
        core_wr_addr = 32'h408;
        core_wr_data = 32'h3;
        step();
        step();
        chk("fill_hold", 32'(core_wr_ready), 32'd0);
        chk("fill_head", mem_addr, 32'h400);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("fill_pop_wv", 32'(dmem_write_valid), 32'd1);
        chk("fill_room", 32'(core_wr_ready), 32'd1);
        step();
        core_wr_req = 1'b0;
        chk("fill_third_in", 32'(core_wr_ready), 32'd0);
        chk("fill_head2", mem_addr, 32'h404);
        mem_req_ready = 1'b1;
        step();
        wait_req("fill_c", 1'b1, 32'h408);
        chk("fill_c_data", mem_wdata, 32'h3);
        step();
        step();
        chk("fill_drained", 32'(mem_req_valid), 32'd0);

        // push and pop in the same cycle
        mem_req_ready = 1'b0;
        push(32'h800, 4'hF, 32'h11);
        step();
        core_wr_req   = 1'b1;
        core_wr_addr  = 32'h804;
        core_wr_data  = 32'h44;
        mem_req_ready = 1'b1;
        step();
        core_wr_req = 1'b0;
        chk("pp_wv", 32'(dmem_write_valid), 32'd1);
        step();
        chk("pp_valid", 32'(mem_req_valid), 32'd1);
        chk("pp_addr", mem_addr, 32'h804);
        chk("pp_data", mem_wdata, 32'h44);
        step();
        step();
        chk("pp_empty", 32'(mem_req_valid), 32'd0);

        // load without hazard bypasses a buffered store
        mem_req_ready = 1'b0;
        push(32'h200, 4'hF, 32'h77);
        core_rd_req  = 1'b1;
        core_rd_addr = 32'h10A;
        step();
        core_rd_req = 1'b0;
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_valid", 32'(mem_req_valid), 32'd1);
        chk("ld_addr", mem_addr, 32'h108);
        chk("ld_strb", 32'(mem_wstrb), 32'h0);
        mem_req_ready = 1'b1;
        step();
        chk("ld_wait_valid", 32'(mem_req_valid), 32'd0);
        chk("ld_wait_busy", 32'(core_rd_ready), 32'd0);
        step();
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hA5A51234;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        chk("ld_rvalid", 32'(dmem_read_valid), 32'd1);
        chk("ld_rdata", dmem_read_data, 32'hA5A51234);
        step();
        chk("ld_rvalid_pulse", 32'(dmem_read_valid), 32'd0);
        chk("ld_rdata_hold", dmem_read_data, 32'hA5A51234);
        wait_req("ld_drain", 1'b1, 32'h200);
        step();
        chk("ld_drain_wv", 32'(dmem_write_valid), 32'd1);

        // load with hazard drains the store first
        mem_req_ready = 1'b0;
        push(32'h300, 4'hF, 32'h11223344);
        core_rd_req  = 1'b1;
        core_rd_addr = 32'h302;
        step();
        core_rd_req = 1'b0;
        chk("hz_we", 32'(mem_we), 32'd1);
        chk("hz_addr", mem_addr, 32'h300);
        chk("hz_data", mem_wdata, 32'h11223344);
        mem_req_ready = 1'b1;
        step();
        chk("hz_wv", 32'(dmem_write_valid), 32'd1);
        wait_req("hz_rd", 1'b0, 32'h300);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFEF00D;
        step();
        mem_rsp_valid = 1'b0;
        chk("hz_rvalid", 32'(dmem_read_valid), 32'd1);
        chk("hz_rdata", dmem_read_data, 32'hCAFEF00D);

        // reset while waiting for a read response
        mem_req_ready = 1'b1;
        core_rd_req   = 1'b1;
        core_rd_addr  = 32'h500;
        step();
        core_rd_req = 1'b0;
        step();
        push(32'h600, 4'hF, 32'h99);
        reset = 1'b0;
        #1;
        chk("mr_rd_ready", 32'(core_rd_ready), 32'd1);
        chk("mr_wr_ready", 32'(core_wr_ready), 32'd1);
        chk("mr_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mr_rdata", dmem_read_data, 32'h0);
        step();
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADDEAD;
        step();
        mem_rsp_valid = 1'b0;
        chk("mr_no_rvalid", 32'(dmem_read_valid), 32'd0);
        chk("mr_rdata_kept", dmem_read_data, 32'h0);
        step();
        step();
        chk("mr_empty", 32'(mem_req_valid), 32'd0);

        // stall: fields stable while memory is not ready
        mem_req_ready = 1'b0;
        push(32'h700, 4'b1100, 32'h55AA0000);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stl_addr", mem_addr, 32'h700);
            chk("stl_strb", 32'(mem_wstrb), 32'hC);
            chk("stl_data", mem_wdata, 32'h55AA0000);
            chk("stl_no_wv", 32'(dmem_write_valid), 32'd0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        chk("stl_wv", 32'(dmem_write_valid), 32'd1);
        step();
        chk("stl_one_pop", 32'(dmem_write_valid), 32'd0);
        chk("stl_idle", 32'(mem_req_valid), 32'd0);
        chk("stl_room", 32'(core_wr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: WBUF_DEPTH, default 2, number of entries in the store write buffer (legal values 1 to 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 core_wr_req  input  1  store request from the writeback stage.
REQ-005 core_wr_addr  input  32  store byte address.
REQ-006 core_wr_byte  input  4  store byte enables, already lane-aligned.
REQ-007 core_wr_data  input  32  store data, already lane-replicated.
REQ-008 core_wr_ready  output  1  store buffer can accept an entry.
REQ-009 core_rd_req  input  1  load request.
REQ-010 core_rd_addr  input  32  load byte address.
REQ-011 core_rd_ready  output  1  controller is idle and can accept a load.
REQ-012 dmem_read_data  output  32  raw load word; the writeback stage extracts the byte or halfword.
REQ-013 dmem_read_valid  output  1  one-cycle pulse; dmem_read_data is valid.
REQ-014 dmem_write_valid  output  1  one-cycle pulse; a buffered store was accepted by memory.
REQ-015 mem_req_valid / mem_req_ready  output / input  1 / 1  request handshake toward memory.
REQ-016 mem_we, mem_addr, mem_wstrb, mem_wdata  output  1, 32, 4, 32  request fields toward memory.
REQ-017 mem_rsp_valid, mem_rsp_data  input  1, 32  read response from memory, arriving any number of cycles (1 or more) after acceptance.

Function
REQ-018 Store push: the block shall push {addr, byte, data} into the FIFO when core_wr_req and core_wr_ready are both high; core_wr_ready shall equal !full, combinationally.
REQ-019 A store presented while the buffer is full shall be neither accepted nor lost; the requester holds it.
REQ-020 A push and a pop in the same cycle shall leave the entry count unchanged, and the FIFO pointers shall wrap modulo WBUF_DEPTH.
REQ-021 FSM states are IDLE, WR_REQ, RD_HAZ, RD_REQ, RD_WAIT; core_rd_ready shall be 1 only in IDLE.
REQ-022 IDLE with core_rd_req: the block shall latch core_rd_addr.
  - Next state is RD_HAZ if any buffered entry has addr[31:2] equal to core_rd_addr[31:2].
  - Otherwise next state is RD_REQ.
  - A load takes priority over draining the buffer.
REQ-023 IDLE with no load and the buffer not empty: next state is WR_REQ.
REQ-024 RD_HAZ: the block shall drain the buffer exactly as in WR_REQ until the buffer is empty, then go to RD_REQ; there is no store-to-load forwarding.
REQ-025 WR_REQ: drive mem_req_valid=1, mem_we=1, and the head entry on the request fields.
  - On mem_req_ready: pop the entry, pulse dmem_write_valid on the next cycle, and return to IDLE (or stay in RD_HAZ when in the hazard drain).
REQ-026 RD_REQ: drive mem_req_valid=1, mem_we=0, mem_wstrb=0, and the latched address; on mem_req_ready, go to RD_WAIT.
REQ-027 RD_WAIT: on mem_rsp_valid, register mem_rsp_data into dmem_read_data, pulse dmem_read_valid on the next cycle, and go to IDLE.
REQ-028 mem_addr shall always be word aligned ({addr[31:2], 2'b00}).
REQ-029 While mem_req_valid=1 and mem_req_ready=0, all request fields shall hold stable.
REQ-030 mem_req_valid shall be 0 in IDLE and in RD_WAIT.
REQ-031 mem_rsp_valid outside RD_WAIT shall be ignored.
REQ-032 dmem_read_data shall hold its value until the next load response.
REQ-033 Only one memory transaction shall be outstanding at a time.
REQ-034 A store is accepted into the buffer while the FSM is busy only if the buffer is not full; the hazard check uses the buffer contents at the cycle the load is accepted.

Reset
REQ-035 On reset=0, the block shall asynchronously force the following, regardless of any in-flight transaction:
  - state = IDLE and buffer empty (pointers and count = 0);
  - mem_req_valid = 0, dmem_read_valid = 0, dmem_write_valid = 0;
  - dmem_read_data = 32'h0, latched address = 32'h0.
REQ-036 A response to a request issued before reset shall be ignored after reset is released.

Verification
REQ-037 Store then idle: addr 0x104, byte 4'b0011, data 0x0000BEEF, mem_req_ready=1 -> mem_addr 0x104, mem_wstrb 0011, mem_we=1 two cycles after push, then dmem_write_valid pulse; buffer empty.
REQ-038 Fill: three stores, mem_req_ready=0, WBUF_DEPTH=2 -> core_wr_ready=0 after the second push; the third is accepted in the cycle after the first pop.
REQ-039 Load with no hazard: buffer holds a store to 0x200; load 0x10A -> read issued first at mem_addr 0x108; rsp 0xA5A5_1234 after 3 cycles -> dmem_read_data=0xA5A51234 with a 1-cycle valid pulse; the store drains afterward.
REQ-040 Load with hazard: buffer holds a store to 0x300; load 0x302 -> the store is issued first, then the read at 0x300.
REQ-041 Reset mid-read: reset asserted in RD_WAIT, then mem_rsp_valid after release -> no dmem_read_valid, state IDLE, buffer empty.
REQ-042 Stall: mem_req_ready low for 4 cycles during WR_REQ -> mem_addr, mem_wstrb and mem_wdata stay constant, with exactly one pop.
